// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: funct codes, ALU op encodings,
// multiplier FSM states and EX/MEM field widths.
package mips_pkg;

  localparam int WB_W  = 2;
  localparam int M_W   = 3;
  localparam int REG_W = 5;
  localparam int FN_W  = 6;

  localparam logic [FN_W-1:0] FN_ADD   = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB   = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND   = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR    = 6'b100101;
  localparam logic [FN_W-1:0] FN_NOR   = 6'b100111;
  localparam logic [FN_W-1:0] FN_SLT   = 6'b101010;
  localparam logic [FN_W-1:0] FN_MFHI  = 6'b010000;
  localparam logic [FN_W-1:0] FN_MFLO  = 6'b010010;
  localparam logic [FN_W-1:0] FN_MULT  = 6'b011000;
  localparam logic [FN_W-1:0] FN_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/ex_stage_mult_unit.sv
// Iterative shift-add multiplier with HI/LO result registers.
// Signed operands are multiplied as magnitudes and the sign is applied at the end.
module mult_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [2*DATA_W-1:0]   prod_q, prod_d, prod_next;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                  neg_q, neg_d;
  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    busy      = 1'b0;
    done      = 1'b0;
    a_neg     = signed_op & a[DATA_W-1];
    b_neg     = signed_op & b[DATA_W-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          mcand_d  = {{DATA_W{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          prod_d   = '0;
          count_d  = '0;
          state_d  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy = 1'b1;
        if (abort) begin
          state_d = MUL_IDLE;
        end else begin
          prod_d   = prod_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == CNT_W'(DATA_W - 1)) begin
            {hi_d, lo_d} = neg_q ? (~prod_next + 1'b1) : prod_next;
            state_d      = MUL_DONE;
          end
        end
      end
      MUL_DONE: begin
        done    = 1'b1;
        state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, ALU control, branch target, destination select,
// EX/MEM pipeline latch and the stalling multiplier.
module ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [WB_W-1:0]   id_ex_wb,
  input  logic [M_W-1:0]    id_ex_m,
  input  logic              regDst,
  input  logic              aluSrc,
  input  logic [1:0]        aluOp,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  output logic              stall,
  output logic [WB_W-1:0]   ex_mem_wb,
  output logic              ex_mem_branch,
  output logic              ex_mem_memRead,
  output logic              ex_mem_memWrite,
  output logic [DATA_W-1:0] ex_mem_target,
  output logic              ex_mem_zero,
  output logic [DATA_W-1:0] ex_mem_alu,
  output logic [DATA_W-1:0] ex_mem_writeData,
  output logic [REG_W-1:0]  ex_mem_dest
);

  alu_op_e           alu_op;
  logic [FN_W-1:0]   funct;
  logic [DATA_W-1:0] op_b, alu_res, hi, lo;
  logic              is_mult, mult_start, mult_busy, mult_done, bubble;

  logic [WB_W-1:0]   wb_q, wb_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [DATA_W-1:0] target_q, target_d, alu_q, alu_d, wdata_q, wdata_d;
  logic              zero_q, zero_d;
  logic [REG_W-1:0]  dest_q, dest_d;

  assign alu_op  = alu_op_e'(aluOp);
  assign funct   = imm[FN_W-1:0];
  assign is_mult = (alu_op == ALUOP_RTYPE) && ((funct == FN_MULT) || (funct == FN_MULTU));
  // The held mult is still in EX during DONE and must not restart as it leaves.
  assign mult_start = is_mult & ~flush & ~mult_done;

  mult_unit #(.DATA_W(DATA_W)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .start     (mult_start),
    .signed_op (funct == FN_MULT),
    .abort     (flush),
    .a         (readData1),
    .b         (readData2),
    .busy      (mult_busy),
    .done      (mult_done),
    .hi        (hi),
    .lo        (lo)
  );

  assign stall  = mult_busy;
  assign bubble = flush | stall;

  always_comb begin
    op_b    = aluSrc ? imm : readData2;
    alu_res = '0;
    case (alu_op)
      ALUOP_ADD: alu_res = readData1 + op_b;
      ALUOP_SUB: alu_res = readData1 - op_b;
      ALUOP_OR:  alu_res = readData1 | op_b;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_res = readData1 + op_b;
          FN_SUB:  alu_res = readData1 - op_b;
          FN_AND:  alu_res = readData1 & op_b;
          FN_OR:   alu_res = readData1 | op_b;
          FN_NOR:  alu_res = ~(readData1 | op_b);
          FN_SLT:  alu_res = DATA_W'($signed(readData1) < $signed(op_b));
          FN_MFHI: alu_res = hi;
          FN_MFLO: alu_res = lo;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wb_d     = bubble ? '0 : id_ex_wb;
    m_d      = bubble ? '0 : id_ex_m;
    dest_d   = bubble ? '0 : (regDst ? rd : rt);
    target_d = npc + (imm << 2);
    zero_d   = (alu_res == '0);
    alu_d    = alu_res;
    wdata_d  = readData2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      m_q      <= '0;
      dest_q   <= '0;
      target_q <= '0;
      zero_q   <= 1'b0;
      alu_q    <= '0;
      wdata_q  <= '0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      dest_q   <= dest_d;
      target_q <= target_d;
      zero_q   <= zero_d;
      alu_q    <= alu_d;
      wdata_q  <= wdata_d;
    end
  end

  assign ex_mem_wb        = wb_q;
  assign ex_mem_branch    = m_q[2];
  assign ex_mem_memRead   = m_q[1];
  assign ex_mem_memWrite  = m_q[0];
  assign ex_mem_target    = target_q;
  assign ex_mem_zero      = zero_q;
  assign ex_mem_alu       = alu_q;
  assign ex_mem_writeData = wdata_q;
  assign ex_mem_dest      = dest_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed and random ALU steps against an
// arithmetic reference, plus multiply latency, abort and reset sequences.
module tb_ex_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, regDst, aluSrc;
  logic [1:0]   id_ex_wb, aluOp;
  logic [2:0]   id_ex_m;
  logic [W-1:0] npc, readData1, readData2, imm;
  logic [4:0]   rt, rd;
  logic         stall, ex_mem_branch, ex_mem_memRead, ex_mem_memWrite, ex_mem_zero;
  logic [1:0]   ex_mem_wb;
  logic [W-1:0] ex_mem_target, ex_mem_alu, ex_mem_writeData;
  logic [4:0]   ex_mem_dest;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [5:0]   fn_tab [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h10, 6'h12, 6'h3F};

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m),
    .regDst(regDst), .aluSrc(aluSrc), .aluOp(aluOp), .npc(npc),
    .readData1(readData1), .readData2(readData2), .imm(imm), .rt(rt), .rd(rd),
    .stall(stall), .ex_mem_wb(ex_mem_wb), .ex_mem_branch(ex_mem_branch),
    .ex_mem_memRead(ex_mem_memRead), .ex_mem_memWrite(ex_mem_memWrite),
    .ex_mem_target(ex_mem_target), .ex_mem_zero(ex_mem_zero), .ex_mem_alu(ex_mem_alu),
    .ex_mem_writeData(ex_mem_writeData), .ex_mem_dest(ex_mem_dest)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: begin
        case (fn)
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h27: return ~(a | b);
          6'h2A: return ($signed(a) < $signed(b)) ? 1 : 0;
          6'h10: return m_hi;
          6'h12: return m_lo;
          default: return '0;
        endcase
      end
    endcase
  endfunction

  task automatic set_nop();
    aluOp = 2'b00; imm = '0; readData1 = '0; readData2 = '0; aluSrc = 1'b0;
    regDst = 1'b0; rt = '0; rd = '0; id_ex_wb = '0; id_ex_m = '0; flush = 1'b0; npc = '0;
  endtask

  task automatic set_rtype(input logic [5:0] fn);
    aluOp = 2'b10; imm = {26'h0, fn}; aluSrc = 1'b0; regDst = 1'b1; flush = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step_check(input string tag);
    logic [W-1:0] exp_alu, exp_tgt, exp_wd;
    logic [4:0]   exp_dest;
    logic         bub;
    #1;
    chk({tag, " stall"}, W'(stall), '0);
    exp_alu  = ref_alu(aluOp, imm[5:0], readData1, aluSrc ? imm : readData2);
    exp_tgt  = npc + imm * 4;
    exp_wd   = readData2;
    bub      = flush;
    exp_dest = bub ? 5'd0 : (regDst ? rd : rt);
    @(posedge clk); #1;
    chk({tag, " alu"},    ex_mem_alu, exp_alu);
    chk({tag, " zero"},   W'(ex_mem_zero), W'(exp_alu == 0));
    chk({tag, " target"}, ex_mem_target, exp_tgt);
    chk({tag, " wdata"},  ex_mem_writeData, exp_wd);
    chk({tag, " dest"},   W'(ex_mem_dest), W'(exp_dest));
    chk({tag, " wb"},     W'(ex_mem_wb), bub ? '0 : W'(id_ex_wb));
    chk({tag, " m"},      W'({ex_mem_branch, ex_mem_memRead, ex_mem_memWrite}),
        bub ? '0 : W'(id_ex_m));
    @(negedge clk);
  endtask

  // Holds a mult in EX until stall drops. abort_at > 0 raises flush (or rst when
  // use_rst) during that stall cycle. Called and returns at a negedge (+ small offset).
  task automatic run_mult(input logic is_signed, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int abort_at, input logic use_rst);
    int n = 0;
    int bad = 0;
    logic fin = 1'b0;
    logic [2*W-1:0] p;
    aluOp = 2'b10; imm = {26'h0, is_signed ? 6'b011000 : 6'b011001};
    readData1 = a; readData2 = b; aluSrc = 1'b0; regDst = 1'b1; rd = 5'd9;
    id_ex_wb = 2'b01; id_ex_m = 3'b010; flush = 1'b0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      #1;
      if (!stall) begin
        fin = 1'b1;
      end else begin
        n++;
        if (n == abort_at) begin
          if (use_rst) rst = 1'b1; else flush = 1'b1;
        end
        @(posedge clk); #1;
        if (ex_mem_wb != 0 || {ex_mem_branch, ex_mem_memRead, ex_mem_memWrite} != 0) bad++;
        if (n == abort_at) begin
          chk("mult stall bubble", W'(bad), '0);
          chk("abort ex_mem_alu zero-or-loaded", W'(use_rst ? (ex_mem_alu == 0) : 1'b1), W'(1));
          @(negedge clk);
          rst = 1'b0;
          set_nop();
          #1;
          chk("abort stall low", W'(stall), '0);
          if (use_rst) begin m_hi = '0; m_lo = '0; end
          return;
        end
        @(negedge clk);
      end
    end
    chk("mult completes in bound", W'(fin), W'(1));
    @(posedge clk);
    if (is_signed) p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    else           p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    m_hi = p[2*W-1:W];
    m_lo = p[W-1:0];
    @(negedge clk);
    chk("mult stall cycles", W'(n), W'(W + 1));
    chk("mult stall bubble", W'(bad), '0);
  endtask

  task automatic check_hilo(input string tag);
    set_nop(); set_rtype(6'h12); rd = 5'd3; id_ex_wb = 2'b10;
    step_check({tag, " mflo"});
    set_nop(); set_rtype(6'h10); rd = 5'd4; id_ex_wb = 2'b10;
    step_check({tag, " mfhi"});
  endtask

  initial begin
    // Reset with non-zero inputs
    rst = 1'b1; flush = 1'b0; aluOp = 2'b00; aluSrc = 1'b1; regDst = 1'b1;
    id_ex_wb = 2'b11; id_ex_m = 3'b111; npc = 32'h40; readData1 = 32'h12;
    readData2 = 32'h34; imm = 32'h56; rt = 5'd7; rd = 5'd8;
    repeat (2) @(posedge clk);
    #1;
    chk("rst alu", ex_mem_alu, '0);
    chk("rst target", ex_mem_target, '0);
    chk("rst wdata", ex_mem_writeData, '0);
    chk("rst ctrl", W'({ex_mem_wb, ex_mem_branch, ex_mem_memRead, ex_mem_memWrite,
                        ex_mem_zero, ex_mem_dest}), '0);
    chk("rst stall", W'(stall), '0);
    @(negedge clk);
    rst = 1'b0;
    set_nop(); set_rtype(6'h10); rd = 5'd2; id_ex_wb = 2'b10;
    step_check("post-reset mfhi");

    // Directed R-type
    set_nop(); set_rtype(6'h22); readData1 = 7; readData2 = 9; rd = 5'd5; rt = 5'd6;
    id_ex_wb = 2'b10;
    step_check("sub 7-9");
    chk("sub value", ex_mem_alu, 32'hFFFF_FFFE);
    set_nop(); set_rtype(6'h2A); readData1 = 7; readData2 = 9; rd = 5'd5; id_ex_wb = 2'b10;
    step_check("slt 7<9");
    chk("slt value", ex_mem_alu, 32'h1);

    // Branch compare
    set_nop(); aluOp = 2'b01; readData1 = 3; readData2 = 3; npc = 32'h100; imm = 4;
    id_ex_m = 3'b100;
    step_check("beq");
    chk("beq target", ex_mem_target, 32'h110);
    chk("beq zero", W'(ex_mem_zero), W'(1));

    // Flush squashes control
    set_nop(); set_rtype(6'h20); readData1 = 1; readData2 = 2; rd = 5'd1;
    id_ex_wb = 2'b10; id_ex_m = 3'b001; flush = 1'b1;
    step_check("flush rtype");

    // Random ALU traffic
    for (int i = 0; i < 40; i++) begin
      readData1 = $urandom;
      readData2 = ($urandom_range(0, 3) == 0) ? readData1 : $urandom;
      aluOp = 2'($urandom_range(0, 3));
      imm = $urandom;
      if (aluOp == 2'b10) imm[5:0] = fn_tab[$urandom_range(0, 8)];
      aluSrc = 1'($urandom_range(0, 1)); regDst = 1'($urandom_range(0, 1));
      rt = 5'($urandom); rd = 5'($urandom); npc = $urandom;
      id_ex_wb = 2'($urandom); id_ex_m = 3'($urandom);
      flush = ($urandom_range(0, 4) == 0);
      step_check("random");
    end

    // Multiplies
    run_mult(1'b1, -32'sd3, 32'd5, 0, 1'b0);
    check_hilo("mult -3*5");
    chk("mult lo const", m_lo, 32'hFFFF_FFF1);
    chk("mult hi const", m_hi, 32'hFFFF_FFFF);
    run_mult(1'b0, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
    check_hilo("multu");
    run_mult(1'b1, $urandom, $urandom, 0, 1'b0);
    check_hilo("mult random");
    run_mult(1'b0, $urandom, $urandom, 0, 1'b0);
    check_hilo("multu random");

    // Mult presented with flush must not start
    set_nop(); set_rtype(6'h18); readData1 = 4; readData2 = 4; id_ex_wb = 2'b01; flush = 1'b1;
    #1;
    chk("flushed mult stall", W'(stall), '0);
    @(posedge clk); #1;
    chk("flushed mult wb", W'(ex_mem_wb), '0);
    @(negedge clk);
    set_nop();
    #1;
    chk("flushed mult no busy", W'(stall), '0);
    @(negedge clk);

    // Abort on the 10th BUSY cycle (11th stall cycle), then reset mid-BUSY
    run_mult(1'b1, 32'd1234, 32'd5678, 11, 1'b0);
    check_hilo("after abort");
    run_mult(1'b0, 32'd77, 32'd99, 6, 1'b1);
    check_hilo("after rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes ID/EX pipeline fields and computes the ALU result, zero flag, branch target and destination register.
- Registers these into the EX/MEM latch that feeds the memory stage.
- Adds an iterative multiplier with HI/LO registers and raises a stall to the hazard unit while a multiply runs.

Parameters:
- DATA_W, 32, datapath width; multiply iterations = DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  taken-branch flush from MEM (PCSrc); squashes the EX instruction.
- id_ex_wb  in  2  {RegWrite, MemToReg}.
- id_ex_m  in  3  {Branch, MemRead, MemWrite}.
- regDst  in  1  1 = rd, 0 = rt.
- aluSrc  in  1  1 = immediate, 0 = readData2.
- aluOp  in  2  00 add, 01 sub, 10 R-type (funct), 11 or (ori).
- npc  in  DATA_W  PC+4.
- readData1, readData2  in  DATA_W  register operands.
- imm  in  DATA_W  sign-extended immediate; funct = imm[5:0].
- rt, rd  in  5  destination candidates.
- stall  out  1  hold PC, IF/ID, ID/EX.
- ex_mem_wb  out  2  registered.
- ex_mem_branch, ex_mem_memRead, ex_mem_memWrite  out  1 each  registered.
- ex_mem_target  out  DATA_W  registered npc + (imm<<2).
- ex_mem_zero  out  1  registered (alu == 0).
- ex_mem_alu  out  DATA_W  registered ALU result.
- ex_mem_writeData  out  DATA_W  registered readData2.
- ex_mem_dest  out  5  registered destination register.

Behaviour:
- ALU ops, combinational:
  - aluOp=10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed), 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu.
  - Any other funct gives result 0.
  - Add/sub wrap modulo 2^DATA_W; no overflow trap.
- Operand B = aluSrc ? imm : readData2.
- dest = regDst ? rd : rt.
- EX/MEM latch: all outputs load on posedge clk, 1-cycle latency. rst clears every registered output to 0.
- Bubble (wb, m, dest forced 0; data fields still load) is loaded when flush=1, or when stall=1.
- Multiplier FSM states IDLE, BUSY, DONE; reset state IDLE, count 0, HI=LO=0.
- IDLE:
  - If aluOp=10, funct is mult/multu and flush=0: stall=1 (combinational).
  - Latch operand magnitudes (mult: abs value, record sign = s1^s2; multu: raw, sign=0). Clear the 2·DATA_W product, count=0, go BUSY.
- BUSY:
  - stall=1.
  - One shift-add step per cycle; count increments.
  - On count=DATA_W-1: final step, write {HI,LO} = sign ? -product : product; go DONE.
- DONE:
  - stall=0.
  - The held mult advances as a normal instruction (its RegWrite is 0 from decode); go IDLE.
- Latency: 1 IDLE cycle + DATA_W BUSY + 1 DONE. stall is high for DATA_W+1 consecutive cycles.
- flush in BUSY or DONE → abort to IDLE next cycle. HI/LO unchanged, stall drops next cycle.
- rst in any state → IDLE, HI/LO=0, stall=0 in the following cycle.
- mfhi/mflo read the current HI/LO. An mfhi immediately after a multiply (in EX the cycle after DONE) sees the new value.
- flush and rst take priority over the mult start.
- No forwarding inside this block; forwarded operands arrive already muxed on readData1/readData2.

Decomposition:
- Shared package (mips_pkg): funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU), aluOp encodings, FSM state encoding, EX/MEM field widths.
- One sub-module: mult_unit (FSM, operand/product registers, HI/LO). Its interface is start/signed/a/b/abort → busy/done/hi/lo.
- ALU, ALU control and the EX/MEM register stay in ex_stage.

Test Plan:
- Reset: assert rst 2 cycles with non-zero inputs → all ex_mem_* = 0, stall = 0, mfhi then returns 0.
- R-type: readData1=7, readData2=9, funct sub, regDst=1, rd=5, wb=10 → next cycle ex_mem_alu=0xFFFFFFFE, zero=0, dest=5, wb=10. Same with funct slt → alu=1.
- Branch: aluOp=01, readData1=readData2=3, npc=0x100, imm=4, m=100 → ex_mem_zero=1, target=0x110, branch=1.
- Signed multiply: mult −3 × 5 held in ID/EX → stall high exactly 33 cycles. Then mflo → ex_mem_alu=0xFFFFFFF1 and mfhi → 0xFFFFFFFF. multu 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE.
- Abort: flush on 10th BUSY cycle → stall low next cycle, HI/LO keep the prior values, EX/MEM holds a bubble (wb=m=0).
- Flush/stall priority: flush=1 with an R-type having wb=10 → ex_mem_wb=0, ex_mem_memWrite=0. rst mid-BUSY → stall=0 and HI=LO=0 next cycle.
